e_mdu: RTL and testbench

E_MDU -- requirements
Module: E_mdu

---
 rtl/e_mdu.sv | 135 +++++++++++++
 tb/tb_e_mdu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div as a fixed-latency
// busy period and commits the precomputed result on the final busy edge.
module e_mdu #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       E_md_op,
    input  logic [WIDTH-1:0] E_rs_val,
    input  logic [WIDTH-1:0] E_rt_val,
    output logic [WIDTH-1:0] E_md_out,
    output logic             E_busy
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } op_e;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] phi_q, phi_d, plo_q, plo_d;

    logic             start;
    logic             is_mult;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic             div_signed, rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag, den, q_mag, r_mag, quot, rem;

    assign is_mult = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU);
    assign start   = (state_q == IDLE) &&
                     (is_mult || (E_md_op == OP_DIV) || (E_md_op == OP_DIVU));
    assign E_busy  = start || (state_q == BUSY);

    // Sign-extended 2W x 2W multiply keeps the low 2W bits equal to the signed product.
    assign prod_u = {{WIDTH{1'b0}}, E_rs_val} * {{WIDTH{1'b0}}, E_rt_val};
    assign prod_s = {{WIDTH{E_rs_val[WIDTH-1]}}, E_rs_val} *
                    {{WIDTH{E_rt_val[WIDTH-1]}}, E_rt_val};

    // Signed divide via magnitudes; most-negative / -1 wraps back to most-negative.
    assign div_signed = (E_md_op == OP_DIV);
    assign rs_neg = div_signed && E_rs_val[WIDTH-1];
    assign rt_neg = div_signed && E_rt_val[WIDTH-1];
    assign rs_mag = rs_neg ? -E_rs_val : E_rs_val;
    assign rt_mag = rt_neg ? -E_rt_val : E_rt_val;
    assign den    = (rt_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : rt_mag;
    assign q_mag  = rs_mag / den;
    assign r_mag  = rs_mag % den;
    assign quot   = (rs_neg ^ rt_neg) ? -q_mag : q_mag;
    assign rem    = rs_neg ? -r_mag : r_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    if (is_mult) begin
                        cnt_d = 8'(MULT_CYCLES);
                        {phi_d, plo_d} = (E_md_op == OP_MULT) ? prod_s : prod_u;
                    end else begin
                        cnt_d = 8'(DIV_CYCLES);
                        // Zero divisor: pending mirrors current HI/LO so commit is a no-op.
                        if (E_rt_val == '0) begin
                            phi_d = hi_q;
                            plo_d = lo_q;
                        end else begin
                            phi_d = rem;
                            plo_d = quot;
                        end
                    end
                end else if (E_md_op == OP_MTHI) begin
                    hi_d = E_rs_val;
                end else if (E_md_op == OP_MTLO) begin
                    lo_d = E_rs_val;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    cnt_d   = '0;
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    always_comb begin
        E_md_out = '0;
        if (E_md_op == OP_MFHI)      E_md_out = hi_q;
        else if (E_md_op == OP_MFLO) E_md_out = lo_q;
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: vector table for results/latency, plus hand
// sequences for busy-period writes, mid-op reset and single-cycle parameters.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic [3:0]  op0, op1;
    logic [31:0] rs0, rt0, rs1, rt1;
    logic [31:0] out0, out1;
    logic        busy0, busy1;

    int errors = 0;
    int checks = 0;

    e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_md_op(op0), .E_rs_val(rs0),
        .E_rt_val(rt0), .E_md_out(out0), .E_busy(busy0)
    );

    e_mdu #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .E_md_op(op1), .E_rs_val(rs1),
        .E_rt_val(rt1), .E_md_out(out1), .E_busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          busy_cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        if (sel == 0) begin op0 = op; rs0 = rs; rt0 = rt; end
        else          begin op1 = op; rs1 = rs; rt1 = rt; end
    endtask

    task automatic set_op(input int sel, input logic [3:0] op);
        if (sel == 0) op0 = op;
        else          op1 = op;
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    function automatic logic [31:0] get_out(input int sel);
        return (sel == 0) ? out0 : out1;
    endfunction

    // Called with the op already driven in cycle 0; counts busy cycles and reads HI/LO.
    task automatic finish_op(input int sel, input string name, input int exp_busy,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n = 0;
        @(negedge clk);
        while (get_busy(sel) && n < 300) begin
            n++;
            @(posedge clk); #1;
            set_op(sel, 4'd5);
            @(negedge clk);
        end
        if (n >= 300) $display("FAIL %s_timeout: busy still high after %0d cycles", name, n);
        check({name, "_busy_cycles"}, n, exp_busy);
        if (n == 0) begin
            @(posedge clk); #1;
            set_op(sel, 4'd5);
        end
        #1;
        check({name, "_hi"}, get_out(sel), exp_hi);
        set_op(sel, 4'd6);
        #1;
        check({name, "_lo"}, get_out(sel), exp_lo);
        set_op(sel, 4'd0);
    endtask

    task automatic run_op(input int sel, input string name, input logic [3:0] op,
                          input logic [31:0] rs, input logic [31:0] rt, input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(posedge clk); #1;
        drive(sel, op, rs, rt);
        finish_op(sel, name, exp_busy, exp_hi, exp_lo);
    endtask

    initial begin
        vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'h3,        6,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{4'd2, 32'hFFFFFFFE, 32'h3,        6,  32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'h2,        11, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 11, 32'h00000000, 32'h80000000};
        vecs[4]  = '{4'd7, 32'h11,       32'h0,        0,  32'h00000011, 32'h80000000};
        vecs[5]  = '{4'd8, 32'h22,       32'h0,        0,  32'h00000011, 32'h00000022};
        vecs[6]  = '{4'd4, 32'd100,      32'h0,        11, 32'h00000011, 32'h00000022};
        vecs[7]  = '{4'd4, 32'd100,      32'd7,        11, 32'h00000002, 32'h0000000E};
        vecs[8]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 11, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{4'd3, 32'hFFFFFFF8, 32'hFFFFFFFD, 11, 32'hFFFFFFFE, 32'h00000002};
        vecs[10] = '{4'd1, 32'h00010000, 32'h00010000, 6,  32'h00000001, 32'h00000000};
        vecs[11] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 6,  32'hFFFFFFFE, 32'h00000001};
        vecs[12] = '{4'd9, 32'h5,        32'h5,        0,  32'hFFFFFFFE, 32'h00000001};
        vecs[13] = '{4'd3, 32'h5,        32'h0,        11, 32'hFFFFFFFE, 32'h00000001};
        vecs[14] = '{4'd8, 32'h1234,     32'h0,        0,  32'hFFFFFFFE, 32'h00001234};

        reset = 1'b0;
        drive(0, 4'd0, '0, '0);
        drive(1, 4'd0, '0, '0);
        #2;
        check("reset_busy", {31'b0, busy0}, 32'h0);
        op0 = 4'd5; #1;
        check("reset_mfhi", out0, 32'h0);
        op0 = 4'd6; #1;
        check("reset_mflo", out0, 32'h0);
        op0 = 4'd0; #1;
        check("none_out_zero", out0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op(0, $sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].busy_cycles, vecs[i].hi, vecs[i].lo);
        end

        // mthi and mflo presented during a mult busy period: mthi ignored, LO stays committed.
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk); #1;
            case (c)
                0: drive(0, 4'd1, 32'd5, 32'd7);
                2: drive(0, 4'd7, 32'hDEAD, 32'd0);
                3: drive(0, 4'd6, 32'd0, 32'd0);
                6: drive(0, 4'd5, 32'd0, 32'd0);
                default: drive(0, 4'd0, 32'd0, 32'd0);
            endcase
            @(negedge clk);
            check($sformatf("busywr_busy_c%0d", c), {31'b0, busy0}, {31'b0, (c <= 5)});
            if (c == 3) check("busywr_mflo_no_intermediate", out0, 32'h1234);
        end
        check("busywr_hi", out0, 32'h0);
        op0 = 4'd6; #1;
        check("busywr_lo", out0, 32'h23);
        op0 = 4'd0;

        // Reset in cycle 3 of a mult.
        @(posedge clk); #1;
        drive(0, 4'd1, 32'd3, 32'd3);
        @(posedge clk); #1;
        op0 = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy0}, 32'h0);
        op0 = 4'd5; #1;
        check("midrst_hi", out0, 32'h0);
        op0 = 4'd6; #1;
        check("midrst_lo", out0, 32'h0);
        op0 = 4'd0;
        @(posedge clk); #1;
        drive(0, 4'd1, 32'd3, 32'd3);
        #1;
        check("rst_start_busy", {31'b0, busy0}, 32'h1);
        reset = 1'b1;
        finish_op(0, "post_reset_mult", 6, 32'h0, 32'h9);

        // Single-cycle latency instance.
        run_op(1, "p1_mult", 4'd1, 32'd6, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 32'hFFFFFFD6);
        run_op(1, "p1_div", 4'd3, 32'd9, 32'd4, 2, 32'h1, 32'h2);
        run_op(1, "p1_divu0", 4'd4, 32'd9, 32'd0, 2, 32'h1, 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
